decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
- Sequential select generator that sits directly upstream of the team's decoders and drives their select input through every code in order.
- Holds each code for a programmable dwell time and also produces the registered one-hot decode of the current code, aligned with sel_out.
- Uses a start/busy/done handshake, with optional continuous looping and abort.
- With SEL_W=1 it drives a 1-bit decoder: sel 0 gives one-hot 01, sel 1 gives one-hot 10.

Parameters:
- SEL_W, 1, width of the select code; 2**SEL_W codes are scanned.
- DWELL, 4, clock cycles each code is held; legal range 1..255.
- CNT_W, 16, width of the completed-pass counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- stop  input  1  abort the current scan; sampled in every state.
- loop_en  input  1  sampled at the end of each pass: 1 = wrap to code 0, 0 = finish.
- sel_out  output  SEL_W  current select code, feeds the downstream decoder input.
- onehot_out  output  2**SEL_W  registered one-hot of sel_out while valid, else all zeros.
- valid  output  1  sel_out/onehot_out are meaningful.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on stop-terminated scan.
- pass_cnt  output  CNT_W  number of completed passes since the last start; wraps modulo 2**CNT_W.

Behaviour:
- Reset (async assert, sync release): state=IDLE; sel_out=0, onehot_out=0, valid=0, busy=0, done=0, aborted=0, pass_cnt=0, dwell counter=0. Reset mid-scan clears everything immediately, with no done or aborted pulse.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, SCAN, FINISH.
- IDLE:
  - start=1 and stop=0 at edge k: after edge k, state=SCAN, sel_out=0, onehot_out=1, valid=1, busy=1, pass_cnt=0, dwell=0.
  - start=1 and stop=1 together: stop wins; stay in IDLE, no pulse.
- SCAN:
  - dwell increments every cycle.
  - When dwell==DWELL-1: dwell resets to 0 and sel_out advances by 1.
  - onehot_out tracks sel_out in the same cycle, computed from the next-state value.
  - So each code is visible for exactly DWELL cycles.
- End of pass (sel_out==2**SEL_W-1 and dwell==DWELL-1):
  - pass_cnt increments.
  - If loop_en=1: sel_out wraps to 0, stay in SCAN.
  - If loop_en=0: go to FINISH.
- FINISH (exactly one cycle): done=1, valid=0, busy=0, onehot_out=0, sel_out=0. Next cycle goes to IDLE and done=0.
- stop=1 in SCAN at edge k:
  - After edge k: state=IDLE, valid=0, busy=0, onehot_out=0, sel_out=0, aborted=1 for one cycle.
  - pass_cnt holds its value.
  - stop beats end-of-pass in the same cycle: aborted, not done.
- start while in SCAN or FINISH is ignored and does not queue.
- start held high across FINISH→IDLE re-launches one cycle after done. Back-to-back scans are legal.
- Pass period is DWELL*2**SEL_W cycles. The first code is visible 1 cycle after start is sampled.
- DWELL=1: the code changes every cycle, and onehot_out never shows two bits set.

Decomposition:
- Shared package scan_pkg:
  - state enum scan_state_t {IDLE, SCAN, FINISH}.
  - function onehot(sel) returning 2**SEL_W bits.
  - constants for the DWELL legal range.
- One natural sub-module: onehot_dec, a combinational SEL_W→2**SEL_W decoder with enable. Instantiate it on the next-state select and register its output. It is reusable by other decoder blocks.
- The FSM, dwell counter and pass counter stay in the top module.

Test Plan:
- Basic scan, SEL_W=1, DWELL=2, loop_en=0. Pulse start at cycle 0 →
  - cycles 1-2: sel=0, onehot=01, valid=1.
  - cycles 3-4: sel=1, onehot=10.
  - cycle 5: done=1, valid=0, busy=0, pass_cnt=1.
  - cycle 6: IDLE.
- Loop mode, SEL_W=2, DWELL=1, loop_en=1 → onehot sequence 0001, 0010, 0100, 1000, 0001… with no gap. pass_cnt increments every 4 cycles. done is never asserted.
- Abort: SEL_W=2, DWELL=3, stop on cycle 5 (sel=1) → next cycle aborted=1, valid=0, onehot=0000, busy=0, pass_cnt=0, no done.
- Collisions:
  - start+stop together in IDLE → nothing happens.
  - start during SCAN → ignored; sequence timing unchanged.
  - stop on the last cycle of a pass → aborted, not done.
- Reset: assert rst_n low mid-scan, asynchronously between clock edges → all outputs zero immediately. After release, start relaunches from sel=0.
- Wrap: CNT_W=2, loop 5 passes → pass_cnt reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the decoder select scanner
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } scan_state_t;

    // Legal dwell range; the dwell counter is sized for the maximum
    localparam int DWELL_MIN   = 1;
    localparam int DWELL_MAX   = 255;
    localparam int DWELL_CNT_W = 8;

    // Widest select code the generic one-hot helper supports
    localparam int MAX_SEL_W = 8;

    // Generic one-hot of a select code; callers keep the low 2**SEL_W bits
    function automatic logic [2**MAX_SEL_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational select-to-one-hot decoder with enable
module onehot_dec #(
    parameter int SEL_W = 1
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   dec
);

    // One bit set at the selected position when enabled, all zeros otherwise
    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - dwell-timed select scanner with registered one-hot decode
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int SEL_W = 1,
    parameter int DWELL = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [SEL_W-1:0]      sel_out,
    output logic [2**SEL_W-1:0]   onehot_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [CNT_W-1:0]      pass_cnt
);

    localparam logic [SEL_W-1:0]       SEL_LAST   = {SEL_W{1'b1}};
    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL - 1);

    if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_dwell_range
        $error("decoder_scan_ctrl: DWELL out of range");
    end

    scan_state_t              state_q, state_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [DWELL_CNT_W-1:0]   dwell_q, dwell_d;
    logic [CNT_W-1:0]         pass_q, pass_d;
    logic                     scan_q, scan_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic [2**SEL_W-1:0]      onehot_q, onehot_d;

    // Next-state, dwell/pass counting and pulse generation; stop outranks end-of-pass
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dwell_d   = dwell_q;
        pass_d    = pass_q;
        scan_d    = scan_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    dwell_d = '0;
                    pass_d  = '0;
                    scan_d  = 1'b1;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d   = IDLE;
                    sel_d     = '0;
                    dwell_d   = '0;
                    scan_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (sel_q == SEL_LAST) begin
                        pass_d = pass_q + 1'b1;
                        sel_d  = '0;
                        if (!loop_en) begin
                            state_d = FINISH;
                            scan_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                dwell_d = '0;
                scan_d  = 1'b0;
            end
        endcase
    end

    // Decode the next select so the registered one-hot lines up with sel_out
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot_dec (
        .en  (scan_d),
        .sel (sel_d),
        .dec (onehot_d)
    );

    // State and output registers; reset clears everything without any pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            dwell_q   <= '0;
            pass_q    <= '0;
            scan_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            onehot_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            dwell_q   <= dwell_d;
            pass_q    <= pass_d;
            scan_q    <= scan_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            onehot_q  <= onehot_d;
        end
    end

    assign sel_out    = sel_q;
    assign onehot_out = onehot_q;
    assign valid      = scan_q;
    assign busy       = scan_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign pass_cnt   = pass_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - randomized model-checked bench for decoder_scan_ctrl
module tb_decoder_scan_ctrl;

    localparam int SEL_W  = 2;
    localparam int DWELL  = 3;
    localparam int CNT_W  = 2;
    localparam int NC     = 4;
    localparam int PERIOD = DWELL * NC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [SEL_W-1:0] sel_out;
    logic [NC-1:0]    onehot_out;
    logic             valid, busy, done, aborted;
    logic [CNT_W-1:0] pass_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(
        .SEL_W (SEL_W),
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .sel_out    (sel_out),
        .onehot_out (onehot_out),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pass_cnt   (pass_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: mode 0 idle, 1 scanning, 2 finish; e counts cycles since the scan began
    int m_mode = 0;
    int m_e = 0;
    int m_passes = 0;
    bit m_ab = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   <= 0;
            m_e      <= 0;
            m_passes <= 0;
            m_ab     <= 1'b0;
        end else begin
            m_ab <= 1'b0;
            case (m_mode)
                0: if (start && !stop) begin
                    m_mode   <= 1;
                    m_e      <= 0;
                    m_passes <= 0;
                end
                1: if (stop) begin
                    m_mode <= 0;
                    m_ab   <= 1'b1;
                end else begin
                    m_e <= m_e + 1;
                    if ((m_e + 1) % PERIOD == 0) begin
                        m_passes <= m_passes + 1;
                        if (!loop_en) m_mode <= 2;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Compare every cycle against the reference, away from the active edge
    always @(negedge clk) begin : cmp
        int  xsel;
        bit  xv;
        xv   = (m_mode == 1);
        xsel = xv ? (m_e / DWELL) % NC : 0;
        check("m_sel", 32'(sel_out), 32'(xsel));
        check("m_onehot", 32'(onehot_out), xv ? (32'd1 << xsel) : 32'd0);
        check("m_valid", 32'(valid), 32'(xv));
        check("m_busy", 32'(busy), 32'(xv));
        check("m_done", 32'(done), 32'(m_mode == 2));
        check("m_aborted", 32'(aborted), 32'(m_ab));
        check("m_pass_cnt", 32'(pass_cnt), 32'(m_passes % (2 ** CNT_W)));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        run(3);
        check("rst_sel", 32'(sel_out), 0);
        check("rst_onehot", 32'(onehot_out), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_pass", 32'(pass_cnt), 0);
        rst_n = 1'b1;
        cyc();

        // basic single pass
        pulse_start();
        check("b1_sel", 32'(sel_out), 0);
        check("b1_onehot", 32'(onehot_out), 1);
        check("b1_valid", 32'(valid), 1);
        run(3);
        check("b4_sel", 32'(sel_out), 1);
        check("b4_onehot", 32'(onehot_out), 2);
        run(8);
        check("b12_sel", 32'(sel_out), 3);
        check("b12_onehot", 32'(onehot_out), 8);
        cyc();
        check("b13_done", 32'(done), 1);
        check("b13_valid", 32'(valid), 0);
        check("b13_busy", 32'(busy), 0);
        check("b13_onehot", 32'(onehot_out), 0);
        check("b13_pass", 32'(pass_cnt), 1);
        cyc();
        check("b14_done", 32'(done), 0);

        // abort on cycle 5
        pulse_start();
        run(4);
        check("a5_sel", 32'(sel_out), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("a6_aborted", 32'(aborted), 1);
        check("a6_valid", 32'(valid), 0);
        check("a6_onehot", 32'(onehot_out), 0);
        check("a6_busy", 32'(busy), 0);
        check("a6_pass", 32'(pass_cnt), 0);
        check("a6_done", 32'(done), 0);
        cyc();
        check("a7_aborted", 32'(aborted), 0);

        // start and stop together in idle
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_valid", 32'(valid), 0);
        check("ss_aborted", 32'(aborted), 0);

        // start during scan is ignored
        pulse_start();
        run(2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("sd4_sel", 32'(sel_out), 1);
        run(10);

        // stop on the last cycle of a pass
        pulse_start();
        run(11);
        check("sl12_sel", 32'(sel_out), 3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("sl_aborted", 32'(aborted), 1);
        check("sl_done", 32'(done), 0);
        check("sl_pass", 32'(pass_cnt), 0);

        // pass counter wrap in loop mode
        loop_en = 1'b1;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            run(k == 0 ? PERIOD : PERIOD);
            check("wrap_pass", 32'(pass_cnt), 32'(wrap_exp[k]));
            check("wrap_done", 32'(done), 0);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        loop_en = 1'b0;

        // asynchronous reset mid-scan
        pulse_start();
        run(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sel", 32'(sel_out), 0);
        check("ar_onehot", 32'(onehot_out), 0);
        check("ar_valid", 32'(valid), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(done), 0);
        check("ar_aborted", 32'(aborted), 0);
        cyc();
        rst_n = 1'b1;
        pulse_start();
        check("ar_relaunch_sel", 32'(sel_out), 0);
        check("ar_relaunch_oh", 32'(onehot_out), 1);
        check("ar_relaunch_valid", 32'(valid), 1);

        // randomized traffic
        repeat (3000) begin
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            loop_en = $urandom_range(0, 1) != 0;
            cyc();
        end
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        run(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
